// File: rtl/adat_in_frame_ctrl.sv
// adat_in_frame_ctrl
//   Sequencing controller for one decoded ADAT input stream. It assembles
//   8 x 24-bit channel samples from 10-bit subframes, writes them into the
//   non-selected bank of a double-banked sample RAM, and flips banks on each
//   complete, error-free frame. It also tracks lock, user bits and errors.
//
// Ports
//   mclk, reset      : master clock, synchronous active-high reset
//   enable           : stream enable (low = abort to HUNT, no frame strobe)
//   frame_done       : one-cycle frame strobe to the decoder
//   sub_data/sub_rdy : decoded subframe {mk,nib,mk,nib} and its valid pulse
//   frame_rdy        : end-of-frame pulse (user bits on sub_data[3:0])
//   stream_error     : decoder framing error
//   ram_we/addr/data : sample RAM write port, addr = {bank, channel}
//   bank_sel         : bank holding the last complete frame
//   bank_ready       : pulse when bank_sel updates
//   user_bits        : user bits of the last complete frame
//   locked/sync_lost : lock status and its falling-edge pulse
//   err_count        : saturating error counter
module adat_in_frame_ctrl #(
  parameter int unsigned FRAME_LEN   = 256,
  parameter int unsigned LOCK_FRAMES = 4,
  parameter int unsigned TIMEOUT_LEN = 512
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        enable,
  output logic        frame_done,
  input  logic [9:0]  sub_data,
  input  logic        sub_rdy,
  input  logic        frame_rdy,
  input  logic        stream_error,
  output logic        ram_we,
  output logic [3:0]  ram_addr,
  output logic [23:0] ram_data,
  output logic        bank_sel,
  output logic        bank_ready,
  output logic [3:0]  user_bits,
  output logic        locked,
  output logic        sync_lost,
  output logic [7:0]  err_count
);

  localparam int unsigned TW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned OW = $clog2(TIMEOUT_LEN + 1);

  typedef enum logic [1:0] {HUNT, ASSEMBLE, WAIT_FR} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] frame_cnt;
  logic [OW-1:0] tmo_cnt;
  logic [2:0]    chan;
  logic [1:0]    part;
  logic [23:0]   shift_reg;
  logic [3:0]    good_cnt;
  logic          lock_full;
  logic          markers_ok;
  logic          err;
  logic          abort;
  logic          take_sub;
  logic          wr_sample;
  logic          start_frame;
  logic          frame_good;
  logic          last_sub;
  logic [7:0]    sub_byte;

  assign lock_full  = (good_cnt == 4'(LOCK_FRAMES));
  assign locked     = lock_full && enable;
  assign frame_done = enable && (frame_cnt == TW'(FRAME_LEN - 1));
  assign markers_ok = sub_data[9] && sub_data[4];
  assign sub_byte   = {sub_data[8:5], sub_data[3:0]};
  assign last_sub   = (chan == 3'd7) && (part == 2'd2);
  assign abort      = err || !enable;

  // Simultaneous sub_rdy/frame_rdy outside HUNT is already caught by the
  // per-state checks: frame_rdy is illegal in ASSEMBLE, sub_rdy in WAIT_FR.
  // The timeout fires on the cycle whose increment would reach TIMEOUT_LEN.
  always_comb begin
    err = stream_error;
    case (state)
      ASSEMBLE: if (frame_rdy || (sub_rdy && !markers_ok)) err = 1'b1;
      WAIT_FR:  if (sub_rdy) err = 1'b1;
      default:  ;
    endcase
    if ((state != HUNT) && !frame_rdy && (tmo_cnt == OW'(TIMEOUT_LEN - 1)))
      err = 1'b1;
  end

  always_ff @(posedge mclk) begin
    if (reset) state <= HUNT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = HUNT;
    end else begin
      case (state)
        HUNT:     if (frame_rdy) state_nxt = ASSEMBLE;
        ASSEMBLE: if (sub_rdy && last_sub) state_nxt = WAIT_FR;
        WAIT_FR:  if (frame_rdy) state_nxt = ASSEMBLE;
        default:  state_nxt = HUNT;
      endcase
    end
  end

  always_comb begin
    take_sub    = 1'b0;
    wr_sample   = 1'b0;
    start_frame = 1'b0;
    frame_good  = 1'b0;
    if (!abort) begin
      case (state)
        HUNT:     start_frame = frame_rdy;
        ASSEMBLE: begin
          take_sub  = sub_rdy;
          wr_sample = sub_rdy && (part == 2'd2);
        end
        WAIT_FR:  begin
          start_frame = frame_rdy;
          frame_good  = frame_rdy;
        end
        default:  ;
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      frame_cnt  <= '0;
      tmo_cnt    <= '0;
      chan       <= '0;
      part       <= '0;
      shift_reg  <= '0;
      good_cnt   <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      bank_sel   <= 1'b0;
      bank_ready <= 1'b0;
      user_bits  <= '0;
      sync_lost  <= 1'b0;
      err_count  <= '0;
    end else begin
      if (!enable || (frame_cnt == TW'(FRAME_LEN - 1))) frame_cnt <= '0;
      else                                              frame_cnt <= frame_cnt + 1'b1;

      if ((state == HUNT) || abort || frame_rdy) tmo_cnt <= '0;
      else                                       tmo_cnt <= tmo_cnt + 1'b1;

      ram_we <= wr_sample;
      if (wr_sample) begin
        ram_addr <= {~bank_sel, chan};
        ram_data <= {shift_reg[15:0], sub_byte};
      end

      if (take_sub) begin
        shift_reg <= {shift_reg[15:0], sub_byte};
        if (part == 2'd2) begin
          part <= '0;
          chan <= chan + 1'b1;
        end else begin
          part <= part + 1'b1;
        end
      end
      if (start_frame) begin
        chan <= '0;
        part <= '0;
      end

      bank_ready <= frame_good;
      if (frame_good) begin
        bank_sel  <= ~bank_sel;
        user_bits <= sub_data[3:0];
        if (!lock_full) good_cnt <= good_cnt + 1'b1;
      end
      if (abort) good_cnt <= '0;

      // Lock state is taken from the count, not the enable-gated output,
      // so dropping enable still reports the loss of lock.
      sync_lost <= abort && lock_full;

      if (err && enable && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_adat_in_frame_ctrl.sv
module tb_adat_in_frame_ctrl;
  localparam int unsigned FRAME_LEN   = 256;
  localparam int unsigned LOCK_FRAMES = 4;
  localparam int unsigned TIMEOUT_LEN = 512;

  logic        mclk = 1'b0;
  logic        reset, enable, sub_rdy, frame_rdy, stream_error;
  logic [9:0]  sub_data;
  logic        frame_done, ram_we, bank_sel, bank_ready, locked, sync_lost;
  logic [3:0]  ram_addr, user_bits;
  logic [23:0] ram_data;
  logic [7:0]  err_count;

  adat_in_frame_ctrl #(
    .FRAME_LEN  (FRAME_LEN),
    .LOCK_FRAMES(LOCK_FRAMES),
    .TIMEOUT_LEN(TIMEOUT_LEN)
  ) dut (
    .mclk        (mclk),
    .reset       (reset),
    .enable      (enable),
    .frame_done  (frame_done),
    .sub_data    (sub_data),
    .sub_rdy     (sub_rdy),
    .frame_rdy   (frame_rdy),
    .stream_error(stream_error),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_data    (ram_data),
    .bank_sel    (bank_sel),
    .bank_ready  (bank_ready),
    .user_bits   (user_bits),
    .locked      (locked),
    .sync_lost   (sync_lost),
    .err_count   (err_count)
  );

  always #5 mclk = ~mclk;

  int checks = 0;
  int errors = 0;

  // Reference model: stream position as "hunting" plus a count of subframes
  // taken in the current frame (24 means waiting for the frame pulse).
  int          m_timer;
  bit          m_hunt;
  int          m_nsub;
  int          m_since;
  int          m_good;
  bit          m_bank;
  logic [3:0]  m_user;
  int          m_err;
  logic [7:0]  m_bytes [3];
  bit          e_we, e_rdy, e_lost;
  logic [3:0]  e_addr;
  logic [23:0] e_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_timer = 0; m_hunt = 1'b1; m_nsub = 0; m_since = 0; m_good = 0;
    m_bank = 1'b0; m_user = '0; m_err = 0;
    e_we = 1'b0; e_rdy = 1'b0; e_lost = 1'b0; e_addr = '0; e_data = '0;
  endtask

  task automatic model_update(input bit en, input bit sr, input logic [9:0] sd,
                              input bit fr, input bit se);
    bit er, ab, was_locked;
    was_locked = (m_good == LOCK_FRAMES);
    er = 1'b0;
    if (en) begin
      if (se) er = 1'b1;
      if (!m_hunt) begin
        if (sr && fr) er = 1'b1;
        if (sr && m_nsub == 24) er = 1'b1;
        if (sr && !(sd[9] && sd[4])) er = 1'b1;
        if (fr && m_nsub < 24) er = 1'b1;
        if (!fr && m_since >= TIMEOUT_LEN) er = 1'b1;
      end
    end
    ab = er || !en;
    e_we = 1'b0;
    e_rdy = 1'b0;
    e_lost = ab && was_locked;
    if (er && m_err < 255) m_err++;
    if (ab) begin
      m_hunt = 1'b1;
      m_good = 0;
    end else if (m_hunt) begin
      if (fr) begin
        m_hunt = 1'b0;
        m_nsub = 0;
      end
    end else if (sr) begin
      m_bytes[m_nsub % 3] = {sd[8:5], sd[3:0]};
      if (m_nsub % 3 == 2) begin
        e_we   = 1'b1;
        e_addr = {~m_bank, 3'(m_nsub / 3)};
        e_data = {m_bytes[0], m_bytes[1], m_bytes[2]};
      end
      m_nsub++;
    end else if (fr) begin
      m_bank = ~m_bank;
      m_user = sd[3:0];
      e_rdy  = 1'b1;
      if (m_good < LOCK_FRAMES) m_good++;
      m_nsub = 0;
    end
    if (m_hunt)  m_since = 0;
    else if (fr) m_since = 1;
    else         m_since++;
    m_timer = en ? (m_timer + 1) % FRAME_LEN : 0;
  endtask

  task automatic check_outputs();
    chk("frame_done", 32'(frame_done), 32'(enable && (m_timer == FRAME_LEN - 1)));
    chk("ram_we", 32'(ram_we), 32'(e_we));
    if (e_we) begin
      chk("ram_addr", 32'(ram_addr), 32'(e_addr));
      chk("ram_data", 32'(ram_data), 32'(e_data));
    end
    chk("bank_sel", 32'(bank_sel), 32'(m_bank));
    chk("bank_ready", 32'(bank_ready), 32'(e_rdy));
    chk("user_bits", 32'(user_bits), 32'(m_user));
    chk("locked", 32'(locked), 32'((m_good == LOCK_FRAMES) && enable));
    chk("sync_lost", 32'(sync_lost), 32'(e_lost));
    chk("err_count", 32'(err_count), 32'(m_err));
  endtask

  task automatic cyc(input bit sr, input logic [9:0] sd, input bit fr, input bit se);
    sub_rdy = sr; sub_data = sd; frame_rdy = fr; stream_error = se;
    model_update(enable, sr, sd, fr, se);
    @(posedge mclk); #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 10'($urandom), 1'b0, 1'b0);
  endtask

  task automatic send_sub(input logic [7:0] b);
    idle(int'($urandom_range(0, 2)));
    cyc(1'b1, {1'b1, b[7:4], 1'b1, b[3:0]}, 1'b0, 1'b0);
  endtask

  task automatic send_fr(input logic [3:0] ub);
    idle(int'($urandom_range(0, 2)));
    cyc(1'b0, {6'($urandom), ub}, 1'b1, 1'b0);
  endtask

  task automatic send_subs(input int n);
    for (int i = 0; i < n; i++) send_sub(8'($urandom));
  endtask

  task automatic send_frame(input bit fixed);
    logic [23:0] s;
    for (int c = 0; c < 8; c++) begin
      s = fixed ? 24'hA5A500 + 24'(c) : 24'($urandom);
      send_sub(s[23:16]);
      send_sub(s[15:8]);
      send_sub(s[7:0]);
    end
  endtask

  task automatic relock();
    send_fr(4'($urandom));
    for (int f = 0; f < LOCK_FRAMES; f++) begin
      send_frame(1'b0);
      send_fr(4'($urandom));
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; sub_rdy = 1'b0; frame_rdy = 1'b0;
    stream_error = 1'b0; sub_data = '0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge mclk); #1;
      check_outputs();
    end
    chk("reset_ram_addr", 32'(ram_addr), 32'h0);
    chk("reset_ram_data", 32'(ram_data), 32'h0);
    reset = 1'b0;

    // Free-running frame strobe while hunting
    idle(520);

    // First frame with fixed channel pattern, then lock
    send_fr(4'h0);
    send_frame(1'b1);
    send_fr(4'h9);
    chk("first_flip_bank", 32'(bank_sel), 32'h1);
    chk("first_user_bits", 32'(user_bits), 32'h9);
    for (int f = 1; f < LOCK_FRAMES; f++) begin
      send_frame(1'b0);
      send_fr(4'($urandom));
    end
    chk("locked_after_frames", 32'(locked), 32'h1);

    // Marker error at subframe index 5 while locked
    send_subs(5);
    cyc(1'b1, 10'h1FF, 1'b0, 1'b0);
    chk("marker_sync_lost", 32'(sync_lost), 32'h1);
    chk("marker_locked", 32'(locked), 32'h0);
    chk("marker_err_count", 32'(err_count), 32'h1);
    idle(4);

    // Short frame, then clean frames
    send_fr(4'($urandom));
    send_subs(20);
    send_fr(4'($urandom));
    send_fr(4'($urandom));
    send_frame(1'b0);
    send_fr(4'($urandom));
    send_frame(1'b0);
    send_fr(4'($urandom));

    // sub_rdy and frame_rdy together in ASSEMBLE
    send_subs(4);
    cyc(1'b1, 10'h3FF, 1'b1, 1'b0);
    idle(3);

    // Timeout after lock
    relock();
    chk("locked_before_timeout", 32'(locked), 32'h1);
    idle(TIMEOUT_LEN + 8);
    chk("timeout_unlocked", 32'(locked), 32'h0);

    // Enable dropped mid-frame
    relock();
    send_subs(10);
    enable = 1'b0;
    idle(300);
    chk("enable_low_locked", 32'(locked), 32'h0);
    enable = 1'b1;
    idle(5);

    // Error counter saturation
    for (int i = 0; i < 300; i++) cyc(1'b0, 10'($urandom), 1'b0, 1'b1);
    chk("err_count_saturated", 32'(err_count), 32'hFF);

    // Reset arriving with a part-2 subframe: no write may follow
    send_fr(4'($urandom));
    send_subs(2);
    reset = 1'b1;
    sub_rdy = 1'b1; sub_data = 10'h3FF; frame_rdy = 1'b0; stream_error = 1'b0;
    model_reset();
    @(posedge mclk); #1;
    check_outputs();
    reset = 1'b0;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
